// File: rtl/addr4u_tr_sched.sv
// rtl/addr4u_tr_sched.sv - two-requester adder scheduler with triple evaluation and majority vote
// One shared adder is evaluated three times per round; a no-majority vote retries up to MAX_RETRY rounds.
module addr4u_tr_sched #(
   parameter int MAX_RETRY = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       v0,
   input  logic       v1,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   output logic       rdy0,
   output logic       rdy1,
   input  logic [1:0] fi_slot,
   input  logic [4:0] fi_mask,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [4:0] rsp_sum,
   output logic       rsp_corr,
   output logic       rsp_err,
   output logic [7:0] corr_cnt,
   output logic [7:0] err_cnt
);

   typedef enum logic [2:0] {IDLE, EV0, EV1, EV2, VOTE} state_t;

   localparam logic [1:0] MAX_R = 2'(MAX_RETRY);

   state_t     state, state_nx;
   logic       last_gnt;
   logic [1:0] retry;
   logic [3:0] op_a, op_b;
   logic       cur_id;
   logic [4:0] r0, r1, r2;

   logic       gnt0, gnt1;
   logic [3:0] add_x, add_y;
   logic [4:0] add_raw, add_out;
   logic       ev_act;
   logic [1:0] ev_idx;
   logic       maj, all_eq;
   logic [4:0] vote_sum;

   always_comb begin
      state_nx = state;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      case (state)
         IDLE: begin
            // last_gnt==1 means requester 0 wins a tie
            if (v0 && (!v1 || last_gnt))
               gnt0 = 1'b1;
            else if (v1)
               gnt1 = 1'b1;
            if (gnt0 || gnt1)
               state_nx = EV0;
         end
         EV0:  state_nx = EV1;
         EV1:  state_nx = EV2;
         EV2:  state_nx = VOTE;
         VOTE: begin
            if (maj)
               state_nx = IDLE;
            else if (retry < MAX_R)
               state_nx = EV0;
            else
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign rdy0 = gnt0;
   assign rdy1 = gnt1;

   always_comb begin
      ev_act = 1'b1;
      ev_idx = 2'd0;
      case (state)
         EV0:     ev_idx = 2'd0;
         EV1:     ev_idx = 2'd1;
         EV2:     ev_idx = 2'd2;
         default: ev_act = 1'b0;
      endcase
   end

   // EV1 swaps operand order so a stuck adder input shows up as a disagreement
   assign add_x   = (state == EV1) ? op_b : op_a;
   assign add_y   = (state == EV1) ? op_a : op_b;
   assign add_raw = {1'b0, add_x} + {1'b0, add_y};
   assign add_out = add_raw ^ ((ev_act && (fi_slot == ev_idx)) ? fi_mask : 5'd0);

   always_comb begin
      maj      = 1'b1;
      vote_sum = r0;
      all_eq   = (r0 == r1) && (r1 == r2);
      if ((r0 == r1) || (r0 == r2))
         vote_sum = r0;
      else if (r1 == r2)
         vote_sum = r1;
      else
         maj = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_gnt  <= 1'b1;
         retry     <= 2'd0;
         op_a      <= 4'd0;
         op_b      <= 4'd0;
         cur_id    <= 1'b0;
         r0        <= 5'd0;
         r1        <= 5'd0;
         r2        <= 5'd0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_sum   <= 5'd0;
         rsp_corr  <= 1'b0;
         rsp_err   <= 1'b0;
         corr_cnt  <= 8'd0;
         err_cnt   <= 8'd0;
      end else begin
         state     <= state_nx;
         rsp_valid <= 1'b0;
         if (gnt0 || gnt1) begin
            op_a     <= gnt1 ? a1 : a0;
            op_b     <= gnt1 ? b1 : b0;
            cur_id   <= gnt1;
            last_gnt <= gnt1;
            retry    <= 2'd0;
         end
         case (state)
            EV0: r0 <= add_out;
            EV1: r1 <= add_out;
            EV2: r2 <= add_out;
            VOTE: begin
               if (maj) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= cur_id;
                  rsp_sum   <= vote_sum;
                  rsp_corr  <= !all_eq;
                  rsp_err   <= 1'b0;
                  if (!all_eq && corr_cnt != 8'hFF)
                     corr_cnt <= corr_cnt + 8'd1;
               end else if (retry < MAX_R) begin
                  retry <= retry + 2'd1;
               end else begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= cur_id;
                  rsp_sum   <= r0;
                  rsp_corr  <= 1'b0;
                  rsp_err   <= 1'b1;
                  if (err_cnt != 8'hFF)
                     err_cnt <= err_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_addr4u_tr_sched.sv
// tb/tb_addr4u_tr_sched.sv - directed and random checks of addr4u_tr_sched against a transaction model
`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_addr4u_tr_sched;
   localparam int MAX_RETRY = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       v0 = 1'b0, v1 = 1'b0;
   logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
   logic [1:0] fi_slot = 2'd3;
   logic [4:0] fi_mask = 5'd0;
   logic       rdy0, rdy1, rsp_valid, rsp_id, rsp_corr, rsp_err;
   logic [4:0] rsp_sum;
   logic [7:0] corr_cnt, err_cnt;

   int total = 0;
   int bad = 0;

   bit         m_last;
   int         m_corr, m_err;
   logic [4:0] msk [0:MAX_RETRY][0:2];

   addr4u_tr_sched #(.MAX_RETRY(MAX_RETRY)) dut (
      .clk(clk), .rst(rst), .v0(v0), .v1(v1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .rdy0(rdy0), .rdy1(rdy1), .fi_slot(fi_slot), .fi_mask(fi_mask),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_corr(rsp_corr), .rsp_err(rsp_err),
      .corr_cnt(corr_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic clr_masks();
      for (int r = 0; r <= MAX_RETRY; r++)
         for (int k = 0; k < 3; k++)
            msk[r][k] = 5'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v0 = 1'b0; v1 = 1'b0; fi_slot = 2'd3; fi_mask = 5'd0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_last = 1'b1; m_corr = 0; m_err = 0;
      `CHK("rst_valid", rsp_valid, 1'b0)
      `CHK("rst_id", rsp_id, 1'b0)
      `CHK("rst_sum", rsp_sum, 5'd0)
      `CHK("rst_corr", rsp_corr, 1'b0)
      `CHK("rst_err", rsp_err, 1'b0)
      `CHK("rst_ccnt", corr_cnt, 8'd0)
      `CHK("rst_ecnt", err_cnt, 8'd0)
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the response cycle.
   // mode: 0 = valids low while busy, 1 = random valids/operands while busy, 2 = valids held
   task automatic issue(input bit rv0, input bit rv1, input logic [3:0] ra0, input logic [3:0] rb0,
                        input logic [3:0] ra1, input logic [3:0] rb1, input int mode);
      bit         g, done, e_corr, e_err;
      logic [3:0] a, b;
      logic [4:0] s, e_sum;
      logic [4:0] r [0:2];
      int         lat;
      v0 = rv0; v1 = rv1; a0 = ra0; b0 = rb0; a1 = ra1; b1 = rb1;
      fi_slot = 2'd3; fi_mask = 5'd0;
      g = (rv0 && rv1) ? ~m_last : rv1;
      #1;
      `CHK("rdy0", rdy0, !g)
      `CHK("rdy1", rdy1, g)
      a = g ? ra1 : ra0;
      b = g ? rb1 : rb0;
      m_last = g;
      done = 1'b0; lat = 5; e_sum = 5'd0; e_corr = 1'b0; e_err = 1'b0;
      for (int rnd = 0; rnd <= MAX_RETRY && !done; rnd++) begin
         s = 5'(a) + 5'(b);
         for (int k = 0; k < 3; k++) r[k] = s ^ msk[rnd][k];
         lat = 4 * rnd + 5;
         if (r[0] == r[1] || r[0] == r[2]) begin
            e_sum = r[0]; e_corr = !(r[0] == r[1] && r[0] == r[2]); e_err = 1'b0; done = 1'b1;
         end else if (r[1] == r[2]) begin
            e_sum = r[1]; e_corr = 1'b1; e_err = 1'b0; done = 1'b1;
         end else if (rnd == MAX_RETRY) begin
            e_sum = r[0]; e_corr = 1'b0; e_err = 1'b1; done = 1'b1;
         end
      end
      if (e_corr && m_corr < 255) m_corr++;
      if (e_err && m_err < 255) m_err++;
      @(posedge clk);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c < lat) begin
            if ((c - 1) % 4 < 3 && msk[(c - 1) / 4][(c - 1) % 4] != 5'd0) begin
               fi_slot = 2'((c - 1) % 4);
               fi_mask = msk[(c - 1) / 4][(c - 1) % 4];
            end else begin
               fi_slot = 2'd3; fi_mask = 5'd0;
            end
            if (mode == 1) begin
               v0 = 1'($urandom); v1 = 1'($urandom);
               a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            end else if (mode == 0) begin
               v0 = 1'b0; v1 = 1'b0;
            end
            #1;
            `CHK("busy_rdy", {rdy0, rdy1}, 2'b00)
            `CHK("early_rsp", rsp_valid, 1'b0)
         end else begin
            fi_slot = 2'd3; fi_mask = 5'd0;
            if (mode != 2) begin v0 = 1'b0; v1 = 1'b0; end
            `CHK("rsp_valid", rsp_valid, 1'b1)
            `CHK("rsp_id", rsp_id, g)
            `CHK("rsp_sum", rsp_sum, e_sum)
            `CHK("rsp_corr", rsp_corr, e_corr)
            `CHK("rsp_err", rsp_err, e_err)
            `CHK("corr_cnt", corr_cnt, 8'(m_corr))
            `CHK("err_cnt", err_cnt, 8'(m_err))
         end
      end
   endtask

   initial begin
      bit rv0, rv1;
      clr_masks();
      do_reset();

      // plain request with carry out
      issue(1'b1, 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 0);
      `CHK("dir_carry_sum", rsp_sum, 5'h10)

      // single corrupted evaluation is outvoted
      clr_masks();
      msk[0][1] = 5'h01;
      issue(1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 4'd0, 0);
      `CHK("dir_corr_sum", rsp_sum, 5'h07)
      `CHK("dir_corr_cnt", corr_cnt, 8'd1)

      // no majority on both rounds
      clr_masks();
      for (int r = 0; r <= MAX_RETRY; r++) begin msk[r][0] = 5'h01; msk[r][1] = 5'h02; end
      issue(1'b1, 1'b0, 4'd2, 4'd2, 4'd0, 4'd0, 0);
      `CHK("dir_err_sum", rsp_sum, 5'h05)
      `CHK("dir_err_cnt", err_cnt, 8'd1)

      // reset in the middle of an operation
      clr_masks();
      v0 = 1'b1; a0 = 4'd5; b0 = 4'd6;
      @(posedge clk);
      v0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_last = 1'b1; m_corr = 0; m_err = 0;
      for (int i = 0; i < 8; i++) begin
         `CHK("rst_mid_valid", rsp_valid, 1'b0)
         `CHK("rst_mid_ccnt", corr_cnt, 8'd0)
         `CHK("rst_mid_ecnt", err_cnt, 8'd0)
         @(negedge clk);
      end
      issue(1'b1, 1'b0, 4'd9, 4'd3, 4'd0, 4'd0, 0);

      // both requesters held valid: alternating grants back to back
      do_reset();
      for (int i = 0; i < 4; i++)
         issue(1'b1, 1'b1, 4'(i), 4'd7, 4'(i + 8), 4'd2, 2);
      v0 = 1'b0; v1 = 1'b0;

      // random traffic with random fault injection
      for (int i = 0; i < 40; i++) begin
         for (int r = 0; r <= MAX_RETRY; r++)
            for (int k = 0; k < 3; k++)
               msk[r][k] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         rv0 = 1'($urandom); rv1 = 1'($urandom);
         if (!rv0 && !rv1) rv0 = 1'b1;
         issue(rv0, rv1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1);
      end

      // error counter saturation
      clr_masks();
      for (int r = 0; r <= MAX_RETRY; r++) begin msk[r][0] = 5'h01; msk[r][1] = 5'h02; end
      for (int i = 0; i < 256; i++)
         issue(1'b1, 1'b0, 4'($urandom), 4'($urandom), 4'd0, 4'd0, 0);
      `CHK("err_sat", err_cnt, 8'hFF)

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
